// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU unit.
package mips_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = 33;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_div_unit_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step
    import mips_div_pkg::*;
(
    input  logic [DIV_WIDTH:0]   rem_in,
    input  logic                 quo_msb,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH:0]   rem_out,
    output logic                 q_bit
);

    logic [DIV_WIDTH+1:0] diff;

    // A borrow out of the top bit means the trial subtraction must be undone.
    always_comb begin
        diff    = {rem_in, quo_msb} - {2'b00, divisor};
        q_bit   = ~diff[DIV_WIDTH+1];
        rem_out = q_bit ? diff[DIV_WIDTH:0] : {rem_in[DIV_WIDTH-1:0], quo_msb};
    end

endmodule

// File: rtl/mips_div_unit.sv
// Iterative 32-bit MIPS DIV/DIVU unit (restoring, one bit per cycle).
// Optional macro DIV_ZERO_FAST_EN: divide-by-zero bypasses the iteration.
module mips_div_unit
    import mips_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        validIn,
    input  logic        sign,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        validOut,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int DATA_W = DIV_WIDTH;

    function automatic logic [DATA_W-1:0] fix_sign(input logic [DATA_W-1:0] mag,
                                                   input logic              neg);
        return neg ? (~mag + DATA_W'(1)) : mag;
    endfunction

    div_state_t          state;
    logic [5:0]          cnt;
    logic [DATA_W:0]     rem;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   dvs;
    logic [DATA_W-1:0]   dvd_raw;
    logic                neg_q;
    logic                neg_r;
    logic                zero_div;

    logic signed [DATA_W-1:0] src_a_s;
    logic signed [DATA_W-1:0] src_b_s;
    logic                     neg_a;
    logic                     neg_b;
    logic [DATA_W-1:0]        mag_a;
    logic [DATA_W-1:0]        mag_b;

    logic [DATA_W:0]     step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   quo_next;

    always_comb begin
        src_a_s  = SrcA;
        src_b_s  = SrcB;
        neg_a    = sign & (src_a_s < 0);
        neg_b    = sign & (src_b_s < 0);
        mag_a    = fix_sign(SrcA, neg_a);
        mag_b    = fix_sign(SrcB, neg_b);
        quo_next = {quo[DATA_W-2:0], step_q};
    end

    div_step u_step (
        .rem_in  (rem),
        .quo_msb (quo[DATA_W-1]),
        .divisor (dvs),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            validOut <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    validOut <= 1'b0;
                    if (validIn) begin
                        dvd_raw  <= SrcA;
                        quo      <= mag_a;
                        dvs      <= mag_b;
                        rem      <= '0;
                        cnt      <= '0;
                        neg_q    <= neg_a ^ neg_b;
                        neg_r    <= neg_a;
                        zero_div <= (SrcB == '0);
`ifdef DIV_ZERO_FAST_EN
                        if (SrcB == '0) begin
                            Hi       <= SrcA;
                            Lo       <= DIV_ZERO_QUOT;
                            validOut <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    rem <= step_rem;
                    quo <= quo_next;
                    cnt <= cnt + 6'd1;
                    // Last step: results land in Hi/Lo together with the pulse.
                    if (cnt == 6'd31) begin
                        state    <= DONE;
                        validOut <= 1'b1;
                        if (zero_div) begin
                            Hi <= dvd_raw;
                            Lo <= DIV_ZERO_QUOT;
                        end else begin
                            Hi <= fix_sign(step_rem[DATA_W-1:0], neg_r);
                            Lo <= fix_sign(quo_next, neg_q);
                        end
                    end
                end
                DONE: begin
                    validOut <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    validOut <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_div_unit.sv
// Scoreboard bench for mips_div_unit: directed vectors, monitor checks each validOut pulse.
module tb_mips_div_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        validIn;
    logic        sign;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        validOut;
    logic [31:0] Hi;
    logic [31:0] Lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;
    int          zero_lat;

    mips_div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .validIn  (validIn),
        .sign     (sign),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .validOut (validOut),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (validOut) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d Hi=%h Lo=%h required no pulse", cyc, Hi, Lo);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (Lo !== mon_e.lo) begin
                    errors++;
                    $display("FAIL lo cyc=%0d got %h expected %h", cyc, Lo, mon_e.lo);
                end
                checks++;
                if (Hi !== mon_e.hi) begin
                    errors++;
                    $display("FAIL hi cyc=%0d got %h expected %h", cyc, Hi, mon_e.hi);
                end
                checks++;
                if (cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL latency pulse at cyc %0d expected cyc %0d", cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic wait_pulse();
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (validOut) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout no validOut within 100 cycles at cyc %0d", cyc);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eh, input logic [31:0] el, input int lat);
        exp_t e;
        @(posedge clk); #1;
        SrcA    = a;
        SrcB    = b;
        sign    = s;
        validIn = 1'b1;
        e.hi  = eh;
        e.lo  = el;
        e.cyc = cyc + lat;
        sb.push_back(e);
        if (lat > 5) begin
            repeat (5) @(negedge clk);
            check_val("hold_hi", Hi, last_hi);
            check_val("hold_lo", Lo, last_lo);
        end
        wait_pulse();
        @(posedge clk); #1;
        validIn = 1'b0;
        last_hi = eh;
        last_lo = el;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n0;
`ifdef DIV_ZERO_FAST_EN
        zero_lat = 1;
`else
        zero_lat = 33;
`endif
        reset_n = 1'b0;
        validIn = 1'b0;
        sign    = 1'b0;
        SrcA    = '0;
        SrcB    = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_val("reset_validOut", {31'd0, validOut}, 32'd0);
        check_val("reset_hi", Hi, 32'd0);
        check_val("reset_lo", Lo, 32'd0);

        run_op(32'd100,        32'd7,          1'b0, 32'd2,          32'd14,         33);
        run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD,  33);
        run_op(32'd7,          32'hFFFF_FFFE,  1'b1, 32'd1,          32'hFFFF_FFFD,  33);
        run_op(32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 32'hFFFF_FFFE,  32'd14,         33);
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  33);
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          33);
        run_op(32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          32'hFFFF_FFFF,  33);
        run_op(32'd5,          32'd9,          1'b0, 32'd5,          32'd0,          33);
        run_op(32'h1234_5678,  32'd0,          1'b0, 32'h1234_5678,  32'hFFFF_FFFF,  zero_lat);
        run_op(32'h8765_4321,  32'd0,          1'b1, 32'h8765_4321,  32'hFFFF_FFFF,  zero_lat);

        // Reset during BUSY abandons the operation.
        @(posedge clk); #1;
        SrcA = 32'd100; SrcB = 32'd7; sign = 1'b0; validIn = 1'b1;
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        validIn = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        check_val("midreset_validOut", {31'd0, validOut}, 32'd0);
        check_val("midreset_hi", Hi, 32'd0);
        check_val("midreset_lo", Lo, 32'd0);
        repeat (40) @(posedge clk);
        last_hi = '0;
        last_lo = '0;
        run_op(32'd20, 32'd3, 1'b0, 32'd2, 32'd6, 33);

        // Back-to-back with validIn held; operands change while busy.
        @(posedge clk); #1;
        SrcA = 32'd9; SrcB = 32'd4; sign = 1'b0; validIn = 1'b1;
        n0 = cyc;
        e.hi = 32'd1; e.lo = 32'd2; e.cyc = n0 + 33;
        sb.push_back(e);
        @(posedge clk); #1;
        SrcA = 32'd15; SrcB = 32'd5;
        e.hi = 32'd0; e.lo = 32'd3; e.cyc = n0 + 67;
        sb.push_back(e);
        wait_pulse();
        wait_pulse();
        @(posedge clk); #1 validIn = 1'b0;

        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_pulses outstanding %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
